sa_cache: RTL and testbench

Two-way set-associative, write-back, write-allocate cache with an integrated miss-handling controller. It sits between the processor datapath and the RAM model and supersedes the direct-mapped cache, whose external control sequencing (check status, write back, refill) moves inside this block. It adds a ready/valid CPU port, a request/acknowledge memory port, per-set LRU replacement, and a full flush of dirty lines.

---
 rtl/sa_cache_pkg.sv | 18 +
 rtl/sa_cache_if.sv | 34 +++
 rtl/sa_cache_way.sv | 59 +++++
 rtl/sa_cache.sv | 215 +++++++++++++++++++++
 tb/tb_sa_cache.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_cache_pkg.sv
// Shared types for the two-way set-associative cache: controller states and the
// tag-width derivation used by the top level and its way storage.
package sa_cache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWback,
        StRefill,
        StFlush
    } state_e;

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned index_w);
        return addr_w - index_w;
    endfunction

endpackage

// File: rtl/sa_cache_if.sv
// CPU request/response, flush and memory request/acknowledge signals of sa_cache.
// slave is the cache side, master is the processor/RAM side.
interface sa_cache_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) ();
    logic              cpu_valid;
    logic              cpu_ready;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              flush_req;
    logic              flush_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, flush_req, mem_ack, mem_rdata,
        output cpu_ready, cpu_rvalid, cpu_rdata, flush_done, mem_req, mem_we, mem_addr,
               mem_wdata
    );

    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata, flush_req, mem_ack, mem_rdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata, flush_done, mem_req, mem_we, mem_addr,
               mem_wdata
    );
endinterface

// File: rtl/sa_cache_way.sv
// One way of the cache: valid/dirty/tag/data per set, asynchronous read and a
// single full-entry write port sharing the same set index.
module sa_cache_way #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] idx_i,
    input  logic               we_i,
    input  logic               wr_valid_i,
    input  logic               wr_dirty_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [DATA_W-1:0]  rd_data_o
);
    localparam int unsigned SETS = 1 << INDEX_W;

    logic [SETS-1:0]   valid_q, valid_d;
    logic [SETS-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (we_i) begin
            valid_d[idx_i] = wr_valid_i;
            dirty_d[idx_i] = wr_dirty_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data storage carries no reset; valid gates its use.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[idx_i]  <= wr_tag_i;
            data_q[idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_data_o  = data_q[idx_i];
endmodule

// File: rtl/sa_cache.sv
// Two-way set-associative write-back cache with LRU replacement, miss handling
// (write-back then refill) and a full flush of dirty lines.
module sa_cache
    import sa_cache_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INDEX_W = 4
) (
    input logic       clk,
    input logic       rst_n,
    sa_cache_if.slave bus
);
    localparam int unsigned TAG_W = tag_width(ADDR_W, INDEX_W);
    localparam int unsigned SETS  = 1 << INDEX_W;

    state_e state_q, state_d;

    logic              req_we_q, req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic              victim_q, victim_d;
    logic [INDEX_W:0]  fcnt_q, fcnt_d;
    logic [SETS-1:0]   lru_q, lru_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              flush_done_q, flush_done_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         rd_valid, rd_dirty, way_we;
    logic [TAG_W-1:0]   rd_tag [2];
    logic [DATA_W-1:0]  rd_data [2];
    logic               wr_valid, wr_dirty;
    logic [TAG_W-1:0]   wr_tag;
    logic [DATA_W-1:0]  wr_data;
    logic               hit0, hit1, hit, hit_way, miss_victim, fway, wb_way;
    logic               ack, mem_phase, line_done, flush_last;

    assign idx        = (state_q == StFlush) ? fcnt_q[INDEX_W:1] : req_addr_q[INDEX_W-1:0];
    assign req_tag    = req_addr_q[ADDR_W-1:INDEX_W];
    assign hit0       = rd_valid[0] && (rd_tag[0] == req_tag);
    assign hit1       = rd_valid[1] && (rd_tag[1] == req_tag);
    assign hit        = hit0 || hit1;
    assign hit_way    = hit1;
    assign miss_victim = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : lru_q[idx]);
    assign fway       = fcnt_q[0];
    assign wb_way     = (state_q == StFlush) ? fway : victim_q;
    // An ack only counts against a request the memory can actually see.
    assign ack        = bus.mem_ack && mem_req_q;
    assign mem_phase  = (state_q == StWback) || (state_q == StRefill) ||
                        ((state_q == StFlush) && rd_dirty[fway]);
    assign line_done  = !rd_dirty[fway] || ack;
    assign flush_last = (fcnt_q == {(INDEX_W + 1){1'b1}});

    for (genvar w = 0; w < 2; w++) begin : g_way
        sa_cache_way #(
            .DATA_W  (DATA_W),
            .INDEX_W (INDEX_W),
            .TAG_W   (TAG_W)
        ) u_way (
            .clk        (clk),
            .rst_n      (rst_n),
            .idx_i      (idx),
            .we_i       (way_we[w]),
            .wr_valid_i (wr_valid),
            .wr_dirty_i (wr_dirty),
            .wr_tag_i   (wr_tag),
            .wr_data_i  (wr_data),
            .rd_valid_o (rd_valid[w]),
            .rd_dirty_o (rd_dirty[w]),
            .rd_tag_o   (rd_tag[w]),
            .rd_data_o  (rd_data[w])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.flush_req) state_d = StFlush;
                      else if (bus.cpu_valid) state_d = StLookup;
            StLookup: if (hit) state_d = StIdle;
                      else if (rd_valid[miss_victim] && rd_dirty[miss_victim]) state_d = StWback;
                      else state_d = StRefill;
            StWback:  if (ack) state_d = StRefill;
            StRefill: if (ack) state_d = StLookup;
            StFlush:  if (line_done && flush_last) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        req_we_d     = req_we_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        victim_d     = victim_q;
        fcnt_d       = fcnt_q;
        lru_d        = lru_q;
        cpu_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        flush_done_d = 1'b0;
        way_we       = 2'b00;
        wr_valid     = 1'b1;
        wr_dirty     = 1'b0;
        wr_tag       = rd_tag[wb_way];
        wr_data      = rd_data[wb_way];
        mem_req_d    = mem_phase && !ack;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        // Memory address/data are captured once as the request rises and held after.
        if (mem_req_d && !mem_req_q) begin
            if (state_q == StRefill) begin
                mem_we_d   = 1'b0;
                mem_addr_d = req_addr_q;
            end else begin
                mem_we_d    = 1'b1;
                mem_addr_d  = {rd_tag[wb_way], idx};
                mem_wdata_d = rd_data[wb_way];
            end
        end
        unique case (state_q)
            StIdle: begin
                if (bus.flush_req) begin
                    fcnt_d = '0;
                end else if (bus.cpu_valid) begin
                    req_we_d    = bus.cpu_we;
                    req_addr_d  = bus.cpu_addr;
                    req_wdata_d = bus.cpu_wdata;
                end
            end
            StLookup: begin
                if (hit) begin
                    way_we[hit_way] = req_we_q;
                    wr_dirty        = 1'b1;
                    wr_tag          = req_tag;
                    wr_data         = req_wdata_q;
                    if (!req_we_q) cpu_rdata_d = rd_data[hit_way];
                    lru_d[idx]      = ~hit_way;
                    cpu_rvalid_d    = 1'b1;
                end else begin
                    victim_d = miss_victim;
                end
            end
            StWback: way_we[victim_q] = ack;
            StRefill: begin
                way_we[victim_q] = ack;
                wr_tag           = req_tag;
                wr_data          = bus.mem_rdata;
            end
            StFlush: begin
                if (line_done) begin
                    way_we[fway] = 1'b1;
                    wr_valid     = 1'b0;
                    fcnt_d       = fcnt_q + 1'b1;
                    if (flush_last) begin
                        lru_d        = '0;
                        flush_done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            victim_q     <= 1'b0;
            fcnt_q       <= '0;
            lru_q        <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            flush_done_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            req_we_q     <= req_we_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            victim_q     <= victim_d;
            fcnt_q       <= fcnt_d;
            lru_q        <= lru_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            flush_done_q <= flush_done_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.cpu_ready  = (state_q == StIdle) && !bus.flush_req;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.flush_done = flush_done_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_sa_cache.sv
// Randomized bench for sa_cache: a set/way/LRU reference model predicts hits, read data
// and memory traffic; a RAM responder checks every memory request against it.
module tb_sa_cache;
    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_cache_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    sa_cache #(.DATA_W(8), .ADDR_W(8), .INDEX_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;
    int next_delay = -1;

    bit         mv   [16][2];
    bit         md   [16][2];
    logic [3:0] mt   [16][2];
    logic [7:0] mdat [16][2];
    bit         mlru [16];
    logic [7:0] shadow [256];
    logic [7:0] ram    [256];
    op_t        exp_q [$];
    op_t        log_q [$];

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic void push_op(input logic we, input logic [7:0] addr,
                                    input logic [7:0] data);
        op_t o;
        o.we = we;
        o.addr = addr;
        o.data = data;
        exp_q.push_back(o);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 16; s++) begin
            mlru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
            end
        end
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 2; w++) begin
                if (mv[s][w] && md[s][w]) push_op(1'b1, {mt[s][w], 4'(s)}, mdat[s][w]);
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
            end
            mlru[s] = 1'b0;
        end
    endfunction

    function automatic void model_access(input bit we, input logic [7:0] addr,
                                         input logic [7:0] wdata, output bit hit,
                                         output logic [7:0] rdata);
        int s = int'(addr[3:0]);
        int w = -1;
        for (int i = 0; i < 2; i++) if (mv[s][i] && mt[s][i] == addr[7:4]) w = i;
        hit = (w >= 0);
        if (!hit) begin
            w = !mv[s][0] ? 0 : (!mv[s][1] ? 1 : int'(mlru[s]));
            if (mv[s][w] && md[s][w]) push_op(1'b1, {mt[s][w], 4'(s)}, mdat[s][w]);
            push_op(1'b0, addr, 8'h00);
            mv[s][w] = 1'b1;
            md[s][w] = 1'b0;
            mt[s][w] = addr[7:4];
            mdat[s][w] = shadow[addr];
        end
        if (we) begin
            mdat[s][w] = wdata;
            md[s][w] = 1'b1;
            shadow[addr] = wdata;
        end
        rdata = mdat[s][w];
        mlru[s] = (w == 0);
    endfunction

    // RAM responder and per-cycle checker of the memory port.
    initial begin : mem_model
        op_t cur;
        op_t want;
        bit seen;
        int wait_cnt;
        seen = 1'b0;
        wait_cnt = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.flush_done) fd_cnt++;
            if (!rst_n || !bus.mem_req) begin
                seen = 1'b0;
                continue;
            end
            if (!seen) begin
                seen = 1'b1;
                cur.we = bus.mem_we;
                cur.addr = bus.mem_addr;
                cur.data = bus.mem_wdata;
                log_q.push_back(cur);
                check("mem_req_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    check("mem_we", int'(cur.we), int'(want.we));
                    check("mem_addr", int'(cur.addr), int'(want.addr));
                    if (want.we) check("mem_wdata", int'(cur.data), int'(want.data));
                end
                wait_cnt = (next_delay >= 0) ? next_delay : int'($urandom_range(0, 3));
            end else begin
                check("mem_stable", int'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), int'(cur));
                check("ready_during_mem", int'(bus.cpu_ready), 0);
            end
            if (wait_cnt == 0) begin
                bus.mem_ack = 1'b1;
                if (cur.we) ram[cur.addr] = cur.data;
                else bus.mem_rdata = ram[cur.addr];
                seen = 1'b0;
            end else begin
                wait_cnt--;
            end
        end
    end

    task automatic do_req(input bit we, input logic [7:0] addr, input logic [7:0] wdata);
        bit hit;
        logic [7:0] er;
        int n;
        model_access(we, addr, wdata, hit, er);
        n = 0;
        @(negedge clk);
        while (!bus.cpu_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("cpu_ready", int'(bus.cpu_ready), 1);
        bus.cpu_valid = 1'b1;
        bus.cpu_we = we;
        bus.cpu_addr = addr;
        bus.cpu_wdata = wdata;
        @(negedge clk);
        bus.cpu_valid = 1'b0;
        n = 1;
        while (!bus.cpu_rvalid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("cpu_rvalid", int'(bus.cpu_rvalid), 1);
        if (hit) check("hit_latency", n, 2);
        else check("miss_latency_gt2", int'(n > 2), 1);
        if (!we) check("cpu_rdata", int'(bus.cpu_rdata), int'(er));
        check("mem_ops_pending", exp_q.size(), 0);
    endtask

    task automatic do_flush();
        int n;
        model_flush();
        @(negedge clk);
        bus.flush_req = 1'b1;
        #1;
        check("ready_low_on_flush", int'(bus.cpu_ready), 0);
        @(negedge clk);
        bus.flush_req = 1'b0;
        n = 0;
        while (!bus.flush_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("flush_done", int'(bus.flush_done), 1);
        check("flush_ops_pending", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit hit;
        logic [7:0] er;
        int n;
        int seen_rv;
        bus.cpu_valid = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 8'h00;
        bus.cpu_wdata = 8'h00;
        bus.flush_req = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
        ram[8'h13] = 8'hA5;
        for (int i = 0; i < 256; i++) shadow[i] = ram[i];
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_mem_req", int'(bus.mem_req), 0);
        check("rst_mem_we", int'(bus.mem_we), 0);
        check("rst_mem_addr", int'(bus.mem_addr), 0);
        check("rst_mem_wdata", int'(bus.mem_wdata), 0);
        check("rst_cpu_rvalid", int'(bus.cpu_rvalid), 0);
        check("rst_cpu_rdata", int'(bus.cpu_rdata), 0);
        check("rst_flush_done", int'(bus.flush_done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", int'(bus.cpu_ready), 1);

        // Cold read miss, then hit.
        log_q.delete();
        do_req(1'b0, 8'h13, 8'h00);
        check("t1_rdata", int'(bus.cpu_rdata), 8'hA5);
        check("t1_refill_addr", int'(log_q[0].addr), 8'h13);
        do_req(1'b0, 8'h13, 8'h00);
        check("t1_hit_no_mem", log_q.size(), 1);

        // LRU victim in set 3 is the dirty 0x23 line.
        do_req(1'b1, 8'h23, 8'h11);
        do_req(1'b1, 8'h33, 8'h22);
        log_q.delete();
        do_req(1'b0, 8'h03, 8'h00);
        check("t2_ops", log_q.size(), 2);
        check("t2_wb", int'(log_q[0]), int'({1'b1, 8'h23, 8'h11}));
        check("t2_refill_addr", int'({log_q[1].we, log_q[1].addr}), int'({1'b0, 8'h03}));

        // Long refill wait; responder checks stability and cpu_ready each cycle.
        next_delay = 10;
        do_req(1'b0, 8'h47, 8'h00);
        next_delay = -1;

        // Flush writes back exactly the dirty lines of sets 0 and 15, in set order.
        do_flush();
        do_req(1'b1, 8'h10, 8'h3C);
        do_req(1'b1, 8'h2F, 8'hC3);
        log_q.delete();
        fd_cnt = 0;
        do_flush();
        @(negedge clk);
        check("t4_ops", log_q.size(), 2);
        check("t4_wb0", int'(log_q[0]), int'({1'b1, 8'h10, 8'h3C}));
        check("t4_wb1", int'(log_q[1]), int'({1'b1, 8'h2F, 8'hC3}));
        check("t4_flush_done_once", fd_cnt, 1);
        check("t4_ram10", int'(ram[8'h10]), 8'h3C);
        log_q.delete();
        do_req(1'b0, 8'h10, 8'h00);
        check("t4_miss_after_flush", int'({log_q[0].we, log_q[0].addr}), int'({1'b0, 8'h10}));
        log_q.delete();
        do_req(1'b0, 8'h2F, 8'h00);
        check("t4_miss2_after_flush", int'(log_q.size() != 0), 1);

        // flush_req and cpu_valid together: flush wins, request served afterwards.
        do_req(1'b1, 8'h05, 8'h99);
        model_flush();
        model_access(1'b0, 8'h05, 8'h00, hit, er);
        @(negedge clk);
        bus.flush_req = 1'b1;
        bus.cpu_valid = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 8'h05;
        #1;
        check("t5_ready_low", int'(bus.cpu_ready), 0);
        @(negedge clk);
        bus.flush_req = 1'b0;
        n = 0;
        seen_rv = 0;
        while (!bus.flush_done && n < 2000) begin
            @(negedge clk);
            if (bus.cpu_rvalid) seen_rv++;
            n++;
        end
        check("t5_flush_done", int'(bus.flush_done), 1);
        check("t5_no_early_rvalid", seen_rv, 0);
        @(negedge clk);
        bus.cpu_valid = 1'b0;
        n = 0;
        while (!bus.cpu_rvalid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t5_rvalid", int'(bus.cpu_rvalid), 1);
        check("t5_rdata", int'(bus.cpu_rdata), 8'h99);
        check("t5_ops_pending", exp_q.size(), 0);

        // Reset during a write-back abandons it; the line misses afterwards.
        do_flush();
        do_req(1'b1, 8'h45, 8'h77);
        do_req(1'b1, 8'h55, 8'h66);
        model_access(1'b0, 8'h65, 8'h00, hit, er);
        next_delay = 1000;
        @(negedge clk);
        bus.cpu_valid = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 8'h65;
        @(negedge clk);
        bus.cpu_valid = 1'b0;
        n = 0;
        while (!(bus.mem_req && bus.mem_we) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_wback_req", int'(bus.mem_req && bus.mem_we), 1);
        check("t6_wback_addr", int'(bus.mem_addr), 8'h45);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_req_drop", int'(bus.mem_req), 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_delay = -1;
        exp_q.delete();
        model_reset();
        for (int i = 0; i < 256; i++) shadow[i] = ram[i];
        check("t6_ram_untouched", int'(ram[8'h45]), 8'h1F);
        log_q.delete();
        do_req(1'b0, 8'h45, 8'h00);
        check("t6_rdata_old", int'(bus.cpu_rdata), 8'h1F);
        check("t6_miss", int'({log_q[0].we, log_q[0].addr}), int'({1'b0, 8'h45}));

        // Random traffic on a few conflicting sets.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 99) < 3) begin
                do_flush();
            end else begin
                do_req(1'($urandom_range(0, 1)),
                       {2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3))},
                       8'($urandom));
            end
        end
        do_flush();
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            if (ram[i] !== shadow[i]) check("final_ram", int'(ram[i]), int'(shadow[i]));
        end
        check("final_ram_sample", int'(ram[8'h10]), int'(shadow[8'h10]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
